mcs4_ram_host_bridge: RTL and testbench

- Bus master that sits directly upstream of the i4002 RAM chips.
- Turns single host requests (PYNQ/PS side, valid/ready) into MCS-4 instruction-cycle traffic: an SRC cycle followed by one I/O-RAM instruction cycle.
- Generates the 8-phase timing and `sync`. Drives `cm_ram` and the data bus, and captures RAM read data from the OR'ed RAM `dbus_out` lines.
- Stands in for the CPU when the RAM array is exercised from the host.

---
 rtl/mcs4_ram_host_bridge.sv | 128 ++++++++++++
 tb/tb_mcs4_ram_host_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mcs4_ram_host_bridge.sv
// rtl/mcs4_ram_host_bridge.sv - host valid/ready to MCS-4 SRC + I/O-RAM instruction cycle bridge
module mcs4_ram_host_bridge #(
   parameter bit         RSP_ON_WRITE = 1'b1,
   parameter logic [3:0] IDLE_DBUS    = 4'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_opa,
   input  logic [7:0] cmd_addr,
   input  logic [3:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_rdata,
   output logic       sync,
   output logic       cm_ram,
   output logic [3:0] dbus_out,
   input  logic [3:0] dbus_in
);

   // WAIT holds an accepted command until the next instruction cycle boundary
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SRC, S_IO, S_RESP} state_t;

   state_t     state, state_nxt;
   logic [2:0] phase;
   logic       aligned;
   logic [3:0] opa_q;
   logic [7:0] addr_q;
   logic [3:0] wdata_q;
   logic       is_read;
   logic       is_write;
   logic       rsp_due;

   // Opcode classes: read-class values are captured; WRR/WPM/RDR fall in neither and finish as writes
   always_comb begin
      is_read  = 1'b0;
      is_write = 1'b0;
      case (opa_q)
         4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7: is_write = 1'b1;
         4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: is_read = 1'b1;
         default: ;
      endcase
      rsp_due = is_read | RSP_ON_WRITE;
   end

   assign sync = (phase == 3'd7);

   // Free-running A1..X3 phase counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase <= 3'd0;
      else     phase <= phase + 3'd1;
   end

   // RAM phase counters are never reset, so hold off commands until the first sync has gone out
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 aligned <= 1'b0;
      else if (phase == 3'd7)  aligned <= 1'b1;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Command latch on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_q   <= 4'h0;
         addr_q  <= 8'h00;
         wdata_q <= 4'h0;
      end else if (cmd_valid && cmd_ready) begin
         opa_q   <= cmd_opa;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
      end
   end

   // Read data sampled at the end of IO X2; non-read commands report zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 rsp_rdata <= 4'h0;
      else if (state == S_IO && phase == 3'd6) rsp_rdata <= is_read ? dbus_in : 4'h0;
   end

   // Next state and bus drive, decoded from registered phase/state only
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      cm_ram    = 1'b0;
      dbus_out  = IDLE_DBUS;
      case (state)
         S_IDLE: begin
            cmd_ready = aligned;
            if (cmd_valid && aligned)
               state_nxt = (phase == 3'd7) ? S_SRC : S_WAIT;
         end
         S_WAIT: begin
            if (phase == 3'd7) state_nxt = S_SRC;
         end
         S_SRC: begin
            if (phase == 3'd6) begin
               cm_ram   = 1'b1;
               dbus_out = addr_q[7:4];
            end else if (phase == 3'd7) begin
               dbus_out = addr_q[3:0];
            end
            if (phase == 3'd7) state_nxt = S_IO;
         end
         S_IO: begin
            if (phase == 3'd4) begin
               cm_ram   = 1'b1;
               dbus_out = opa_q;
            end else if (phase == 3'd6 && is_write) begin
               dbus_out = wdata_q;
            end
            if (phase == 3'd7) state_nxt = rsp_due ? S_RESP : S_IDLE;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mcs4_ram_host_bridge.sv
// tb/tb_mcs4_ram_host_bridge.sv - directed scoreboard bench for mcs4_ram_host_bridge with an i4002 array model
module tb_mcs4_ram_host_bridge;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_opa = 4'h0;
   logic [7:0] cmd_addr = 8'h00;
   logic [3:0] cmd_wdata = 4'h0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_rdata;
   logic       sync;
   logic       cm_ram;
   logic [3:0] dbus_out;
   logic [3:0] dbus_in;

   int checks = 0;
   int failures = 0;
   int k = 0;
   logic [3:0] exp_q[$];

   mcs4_ram_host_bridge dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opa(cmd_opa),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sync(sync), .cm_ram(cm_ram), .dbus_out(dbus_out), .dbus_in(dbus_in)
   );

   always #5 clk = ~clk;

   // Edges since reset release; phase expected at that point is k % 8
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   // i4002 array model: own free-running phase resynced by sync, never reset
   logic [2:0] rp = 3'd5;
   logic       src_p = 1'b0;
   logic       io = 1'b0;
   logic [3:0] src_hi = 4'h0;
   logic [7:0] src = 8'h00;
   logic [3:0] opa_l = 4'h0;
   logic [3:0] mem [256];
   logic [3:0] stat [16][4];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 4'h0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 4; j++) stat[i][j] = 4'h0;
   end

   always @(posedge clk) begin
      rp <= sync ? 3'd0 : rp + 3'd1;
      if (rp == 3'd4) begin
         io <= cm_ram;
         if (cm_ram) opa_l <= dbus_out;
      end
      if (rp == 3'd6) begin
         src_p <= cm_ram;
         if (cm_ram) src_hi <= dbus_out;
         if (io && !cm_ram) begin
            if (opa_l == 4'h0) mem[src] <= dbus_out;
            else if (opa_l >= 4'h4 && opa_l <= 4'h7) stat[src[7:4]][opa_l - 4'h4] <= dbus_out;
         end
      end
      if (rp == 3'd7 && src_p) src <= {src_hi, dbus_out};
   end

   always_comb begin
      dbus_in = 4'h0;
      if (rp == 3'd6 && io) begin
         if (opa_l == 4'h9) dbus_in = mem[src];
         else if (opa_l >= 4'hC) dbus_in = stat[src[7:4]][opa_l - 4'hC];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, expect a response with rdata exp; optionally stall rsp_ready for hold clocks
   task automatic send(input string tag, input logic [3:0] opa, input logic [7:0] addr,
                       input logic [3:0] wd, input logic [3:0] exp, input int hold);
      int n;
      int p;
      int lat;
      logic [3:0] e;
      cmd_opa = opa; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
      exp_q.push_back(exp);
      n = 0;
      while (!cmd_ready && n < 40) begin tick(); n++; end
      chk({tag, "_ready"}, cmd_ready, 1'b1);
      p = k % 8;
      tick();
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin tick(); lat++; end
      chk({tag, "_latency"}, lat, (8 - p) + 16);
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, rsp_valid, 1'b1);
         chk({tag, "_hold_rdata"}, rsp_rdata, e);
         chk({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
         chk({tag, "_hold_cm_ram"}, cm_ram, 1'b0);
         chk({tag, "_hold_sync"}, sync, (k % 8) == 7);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
   endtask

   initial begin
      int n;
      cmd_valid = 1'b1; cmd_opa = 4'h0; cmd_addr = 8'h25; cmd_wdata = 4'hA;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 4'h0);
      chk("rst_sync", sync, 1'b0);
      chk("rst_cm_ram", cm_ram, 1'b0);
      chk("rst_dbus_out", dbus_out, 4'h0);
      #21 rst = 1'b0;

      // cmd_ready held low until the first sync has been issued
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("align_cmd_ready", cmd_ready, k >= 8);
         chk("align_sync", sync, (k % 8) == 7);
      end

      send("wrm25", 4'h0, 8'h25, 4'hA, 4'h0, 0);
      send("rdm25", 4'h9, 8'h25, 4'h0, 4'hA, 0);
      send("rdm26", 4'h9, 8'h26, 4'h0, 4'h0, 0);
      send("wrm45", 4'h0, 8'h45, 4'h9, 4'h0, 0);
      send("rdm05", 4'h9, 8'h05, 4'h0, 4'h0, 0);
      send("rdm45", 4'h9, 8'h45, 4'h0, 4'h9, 0);
      send("wr2_30", 4'h6, 8'h30, 4'h7, 4'h0, 0);
      send("rd2_30", 4'hE, 8'h30, 4'h0, 4'h7, 0);
      send("rdr", 4'hA, 8'h30, 4'h0, 4'h0, 0);
      send("hold", 4'h9, 8'h25, 4'h0, 4'hA, 40);

      // Reset during IO phase 2 of a WRM that would overwrite 8'h25
      cmd_opa = 4'h0; cmd_addr = 8'h25; cmd_wdata = 4'h5; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 40) begin tick(); n++; end
      chk("rst_wrm_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while ((k % 8) != 0 && n < 20) begin tick(); n++; end
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      chk("mid_cmd_ready", cmd_ready, 1'b0);
      chk("mid_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rsp_rdata", rsp_rdata, 4'h0);
      chk("mid_sync", sync, 1'b0);
      chk("mid_cm_ram", cm_ram, 1'b0);
      chk("mid_dbus_out", dbus_out, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
         chk("realign_no_rsp", rsp_valid, 1'b0);
      end
      chk("realign_ready", cmd_ready, 1'b1);
      chk("realign_clocks", k, 8);
      send("rdm25_after_rst", 4'h9, 8'h25, 4'h0, 4'hA, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
